stream_demux_1xn: RTL
=====================

Name: stream_demux_1xn

Overview:
- Parameterised, registered successor to the 1x4 combinational demux.
- Accepts one data word per valid/ready handshake on a single input stream.
- Routes the word to one of NCH output channels, or broadcasts it to all of them.
- Holds the word until every targeted channel has accepted it. Out-of-range selects are dropped and counted. Sits between a single producer and NCH independent consumers.

Parameters:
- DW, 8, data width in bits.
- NCH, 4, number of output channels (2..16).
- SELW, 2, select width; must satisfy 2^SELW >= NCH.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset, sampled on the rising edge of clk.
- in_valid  in  1  input word valid.
- in_ready  out  1  block can accept an input this cycle.
- in_data  in  DW  input word.
- in_sel  in  SELW  target channel index; ignored when in_bcast=1.
- in_bcast  in  1  route the word to all NCH channels.
- out_valid  out  NCH  per-channel valid; bit k means channel k holds an undelivered word.
- out_ready  in  NCH  per-channel ready from the consumers.
- out_data  out  DW  held word, shared by all channels.
- err_drop  out  1  one-cycle pulse when an out-of-range select is dropped.
- drop_cnt  out  8  saturating count of dropped words.

Behaviour:
- Reset, while rst_n=0 at a clock edge:
  - pend mask = 0, so out_valid = 0.
  - out_data = 0.
  - err_drop = 0.
  - drop_cnt = 0.
  - Any held or partially delivered word is discarded; no output transfer completes in that cycle.
- State is a single holding register plus the pend[NCH-1:0] mask. The block is IDLE when pend==0 and HOLD when pend!=0.
- out_valid = pend, combinationally.
- Channel k transfer: occurs when pend[k] & out_ready[k] at a clock edge; pend[k] clears at that edge. Channels drain independently and in any order.
- last = (pend & ~out_ready) == 0, i.e. every remaining pending bit completes this cycle (true in IDLE).
- in_ready = last. This is a combinational path from out_ready to in_ready, which is permitted. in_ready does not depend on in_valid.
- Accept: occurs when in_valid & in_ready at a clock edge.
  - Broadcast (in_bcast=1): pend <= all ones; out_data <= in_data.
  - Routed (in_bcast=0, in_sel < NCH): pend <= one-hot(in_sel); out_data <= in_data.
  - Dropped (in_bcast=0, in_sel >= NCH):
    - pend <= 0; out_data is unchanged.
    - err_drop <= 1 for exactly one cycle.
    - drop_cnt <= drop_cnt+1, saturating at 255.
- Same-edge completion and accept: when the final pending transfer and a new accept coincide, the new word loads with zero bubble. This gives a sustained throughput of 1 word/cycle for single-channel traffic with out_ready held high.
- No accept while not last: the pend bits that completed are cleared; out_data holds.
- out_data changes only on an accepted, non-dropped word. It is stable whenever pend != 0.
- Latency: an accepted word appears on out_valid/out_data the cycle after acceptance (1 cycle).
- err_drop deasserts on every cycle without a drop.

Test Plan:
- Routed sweep:
  - Stimulus: rst_n=0 for 2 cycles, then release with out_ready=4'b1111. Send data 8'hA0..8'hA3 with sel=0..3 on consecutive cycles.
  - Required: out_valid = 4'b0001, 4'b0010, 4'b0100, 4'b1000, each one cycle after its accept, with out_data A0..A3. in_ready stays 1 throughout.
- Broadcast with staggered ready:
  - Stimulus: bcast with data 8'h5C and out_ready=0, then raise out_ready bits one per cycle: bit0, bit2, bit1, bit3.
  - Required: pend goes 1111 -> 1110 -> 1010 -> 1000 -> 0000. in_ready=0 until the cycle out_ready[3]=1. out_data=8'h5C throughout.
- Back-pressure and zero bubble:
  - Stimulus: hold channel 2 with out_ready[2]=0 while in_valid=1, sel=1, data=8'h11 is presented. Then assert out_ready[2].
  - Required: in_ready=0 until out_ready[2]=1. The new word is accepted in that same cycle, and out_valid=4'b0010 with out_data=8'h11 on the next cycle.
- Drop path (NCH=3, SELW=2):
  - Stimulus: send sel=3, bcast=0, 300 times.
  - Required: err_drop pulses once per word, out_valid stays 0, out_data is unchanged, and drop_cnt saturates at 255.
- Mid-operation reset:
  - Stimulus: with pend=4'b1111 from a broadcast, drive rst_n=0 for one cycle while out_ready=4'b1111.
  - Required: the next cycle shows out_valid=0, out_data=0, drop_cnt=0, and in_ready=1.
- Out-of-order drain:
  - Stimulus: bcast with data 8'hFF, then out_ready=4'b1001 followed by 4'b0110.
  - Required: pend 1111 -> 0110 -> 0000, with in_ready=1 in the second cycle.

Source files
------------

// File: rtl/stream_demux_1xn.sv
`default_nettype none
// ============================================================================
// Module      : stream_demux_1xn
// Description : Registered 1-to-NCH stream demultiplexer. Accepts one word per
//               valid/ready handshake, holds it and presents it to a single
//               selected channel or to all channels (broadcast) until every
//               targeted channel has taken it. Words with an out-of-range
//               select are dropped, flagged and counted.
// Revision    : 1.0 - initial release
// ============================================================================
module stream_demux_1xn #(
  parameter int DW   = 8,
  parameter int NCH  = 4,
  parameter int SELW = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    in_data,
  input  logic [SELW-1:0]  in_sel,
  input  logic             in_bcast,
  output logic [NCH-1:0]   out_valid,
  input  logic [NCH-1:0]   out_ready,
  output logic [DW-1:0]    out_data,
  output logic             err_drop,
  output logic [7:0]       drop_cnt
);

  // One extra bit so NCH itself is representable when 2^SELW == NCH.
  localparam logic [SELW:0]  C_NCH      = (SELW + 1)'(NCH);
  localparam logic [NCH-1:0] C_ONE      = {{(NCH-1){1'b0}}, 1'b1};
  localparam logic [7:0]     C_CNT_MAX  = 8'hFF;

  logic [NCH-1:0] r_pend;
  logic [DW-1:0]  r_data;
  logic           r_err_drop;
  logic [7:0]     r_drop_cnt;

  logic           w_last;
  logic           w_accept;
  logic           w_in_range;
  logic [NCH-1:0] w_onehot;

  // The held word is fully delivered this cycle when no pending channel is
  // still stalled; this lets a new word load on the same edge (zero bubble).
  always_comb begin
    w_last     = ((r_pend & ~out_ready) == '0);
    w_accept   = in_valid & w_last;
    w_in_range = ({1'b0, in_sel} < C_NCH);
    w_onehot   = C_ONE << in_sel;
  end

  // Pending mask, held word and drop bookkeeping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pend     <= '0;
      r_data     <= '0;
      r_err_drop <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      r_err_drop <= 1'b0;
      if (w_accept) begin
        // Any still-pending bits are completing on this edge, so the mask
        // can be overwritten outright.
        if (in_bcast) begin
          r_pend <= '1;
          r_data <= in_data;
        end else if (w_in_range) begin
          r_pend <= w_onehot;
          r_data <= in_data;
        end else begin
          // Dropped word: nothing to deliver, last good word stays visible.
          r_pend     <= '0;
          r_err_drop <= 1'b1;
          if (r_drop_cnt != C_CNT_MAX) begin
            r_drop_cnt <= r_drop_cnt + 8'd1;
          end
        end
      end else begin
        // Channels drain independently; each clears as its consumer takes it.
        r_pend <= r_pend & ~out_ready;
      end
    end
  end

  assign in_ready  = w_last;
  assign out_valid = r_pend;
  assign out_data  = r_data;
  assign err_drop  = r_err_drop;
  assign drop_cnt  = r_drop_cnt;

endmodule
`default_nettype wire
